// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED step counter.
// Holds the step FSM state type and the default parameter values used by
// led_step_counter and btn_debounce.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam int DEF_WIDTH         = 6;
    localparam int DEF_DEB_CYCLES    = 16;
    localparam int DEF_HOLD_CYCLES   = 1024;
    localparam int DEF_REPEAT_CYCLES = 256;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
// Ports:
//   CLK      - system clock, rising edge
//   BTN_RST  - asynchronous active-high reset
//   btn_i    - raw asynchronous button level
//   deb_o    - debounced level
// The debounced level flips only after the synchronised input has disagreed
// with it for DEB_CYCLES consecutive samples plus the toggling edge itself.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic CLK,
    input  logic BTN_RST,
    input  logic btn_i,
    output logic deb_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          meta_q;
    logic          sync_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge BTN_RST) begin
        if (BTN_RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    // A full run of DEB_CYCLES disagreeing samples must already be counted
    // before the level flips, so any shorter glitch is discarded.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/led_step_counter.sv
// Button-driven up/down LED counter with debounce and auto-repeat.
// Ports:
//   CLK      - system clock, rising edge
//   BTN_RST  - asynchronous active-high reset
//   BTN_C    - raw step button (active-high)
//   BTN_DIR  - raw direction switch, 0 = up, 1 = down
//   LED      - registered count
//   LIMIT    - one-cycle pulse when a step wraps or is clamped
// A press steps once; holding it for HOLD_CYCLES starts auto-repeat with
// one step every REPEAT_CYCLES.
module led_step_counter
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int SATURATE      = 0
) (
    input  logic             CLK,
    input  logic             BTN_RST,
    input  logic             BTN_C,
    input  logic             BTN_DIR,
    output logic [WIDTH-1:0] LED,
    output logic             LIMIT
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic             deb;
    logic             dir_meta_q, dir_q;
    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             limit_q, limit_d;
    logic             step;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_c (
        .CLK    (CLK),
        .BTN_RST(BTN_RST),
        .btn_i  (BTN_C),
        .deb_o  (deb)
    );

    always_ff @(posedge CLK or posedge BTN_RST) begin
        if (BTN_RST) begin
            dir_meta_q <= 1'b0;
            dir_q      <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            led_q      <= '0;
            limit_q    <= 1'b0;
        end else begin
            dir_meta_q <= BTN_DIR;
            dir_q      <= dir_meta_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            led_q      <= led_d;
            limit_q    <= limit_d;
        end
    end

    // HOLD/REPEAT are only left when deb is low, so deb high while in IDLE
    // always marks a fresh rising edge of the debounced button.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (deb) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!deb) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REPEAT: begin
                if (!deb) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Count datapath; LIMIT is registered alongside LED so both change on
    // the same edge.
    always_comb begin
        led_d   = led_q;
        limit_d = 1'b0;
        if (step) begin
            if (!dir_q) begin
                if (led_q == {WIDTH{1'b1}}) begin
                    limit_d = 1'b1;
                    led_d   = (SATURATE != 0) ? led_q : '0;
                end else begin
                    led_d = led_q + WIDTH'(1);
                end
            end else begin
                if (led_q == '0) begin
                    limit_d = 1'b1;
                    led_d   = (SATURATE != 0) ? led_q : {WIDTH{1'b1}};
                end else begin
                    led_d = led_q - WIDTH'(1);
                end
            end
        end
    end

    assign LED   = led_q;
    assign LIMIT = limit_q;

endmodule
